// File: rtl/commit_retire_pkg.sv
// Shared types for the commit/retire stage: ROB entry layout, state enum, widths.
package commit_retire_pkg;

    localparam int unsigned COMMIT_WIDTH     = 4;
    localparam int unsigned ROB_ID_WIDTH     = 4;
    localparam int unsigned PHY_REG_ID_WIDTH = 6;

    localparam int unsigned ExceptionCauseWidth = 5;
    localparam int unsigned PcWidth             = 32;
    localparam int unsigned RetireCntWidth      = $clog2(COMMIT_WIDTH + 1);

    typedef struct packed {
        logic                           finish;
        logic                           has_exception;
        logic [ExceptionCauseWidth-1:0] exception_id;
        logic [PcWidth-1:0]             pc;
        logic                           rd_valid;
        logic [PHY_REG_ID_WIDTH-1:0]    old_phy_id;
    } rob_item_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } commit_state_t;

    // ROB id probed by commit slot; wraps modulo the ROB depth by truncation.
    function automatic logic [ROB_ID_WIDTH-1:0] slot_rob_id(
        input logic [ROB_ID_WIDTH-1:0] head,
        input int unsigned             slot
    );
        return head + ROB_ID_WIDTH'(slot);
    endfunction

endpackage

// File: rtl/commit_retire_select.sv
// Retire mask generator: a slot pops only if it and every older slot are retireable.
module commit_retire_select
    import commit_retire_pkg::*;
(
    input  logic                    head_valid_i,
    input  logic [COMMIT_WIDTH-1:0] id_valid_i,
    input  logic [COMMIT_WIDTH-1:0] finish_i,
    input  logic [COMMIT_WIDTH-1:0] has_exception_i,
    output logic [COMMIT_WIDTH-1:0] pop_o,
    output logic                    head_exception_o
);

    logic [COMMIT_WIDTH-1:0] ok;
    logic                    run;

    always_comb begin
        ok  = {COMMIT_WIDTH{head_valid_i}} & id_valid_i & finish_i & ~has_exception_i;
        run = 1'b1;
        pop_o = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            run      = run & ok[i];
            pop_o[i] = run;
        end
        head_exception_o = head_valid_i & id_valid_i[0] & finish_i[0] & has_exception_i[0];
    end

endmodule

// File: rtl/count_one.sv
// Counts set bits of data_i; with CONTINUOUS=1 only the unbroken run starting at bit 0.
module count_one #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          CONTINUOUS = 1'b0,
    parameter int unsigned CNT_WIDTH  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     data_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic run;

    always_comb begin
        count_o = '0;
        run     = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CONTINUOUS) begin
                run     = run & data_i[i];
                count_o = count_o + CNT_WIDTH'(run);
            end else begin
                count_o = count_o + CNT_WIDTH'(data_i[i]);
            end
        end
    end

endmodule

// File: rtl/commit_retire.sv
// In-order retire stage behind the ROB: pops finished head entries, frees old phys regs,
// flushes on a head exception. COMMIT_RETIRE_PERF_COUNTER_EN adds commit_retired_count.
module commit_retire
    import commit_retire_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROB_ID_WIDTH-1:0]        rob_commit_retire_head_id,
    input  logic                           rob_commit_retire_head_id_valid,
    output logic [ROB_ID_WIDTH-1:0]        commit_rob_retire_id [COMMIT_WIDTH],
    input  rob_item_t                      rob_commit_retire_data [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0]        rob_commit_retire_id_valid,
    output logic [COMMIT_WIDTH-1:0]        commit_rob_retire_pop,
    output logic                           commit_rob_flush,
    output logic [PHY_REG_ID_WIDTH-1:0]    commit_phy_release_id [COMMIT_WIDTH],
    output logic [COMMIT_WIDTH-1:0]        commit_phy_release_valid,
    output logic                           commit_redirect_valid,
    output logic [PcWidth-1:0]             commit_redirect_pc,
    output logic [ExceptionCauseWidth-1:0] commit_exception_cause
`ifdef COMMIT_RETIRE_PERF_COUNTER_EN
    ,
    output logic [63:0]                    commit_retired_count
`endif
);

    commit_state_t                  state_q, state_d;
    logic                           flush_q;
    logic [PcWidth-1:0]             pc_q, pc_d;
    logic [ExceptionCauseWidth-1:0] cause_q, cause_d;
    logic [COMMIT_WIDTH-1:0]        rel_valid_q, rel_valid_d;
    logic [PHY_REG_ID_WIDTH-1:0]    rel_id_q [COMMIT_WIDTH];
    logic [PHY_REG_ID_WIDTH-1:0]    rel_id_d [COMMIT_WIDTH];

    logic [COMMIT_WIDTH-1:0]        finish, has_exc, sel_pop, pop;
    logic                           head_exc;

    always_comb begin
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            finish[i]               = rob_commit_retire_data[i].finish;
            has_exc[i]              = rob_commit_retire_data[i].has_exception;
            commit_rob_retire_id[i] = slot_rob_id(rob_commit_retire_head_id, i);
        end
    end

    commit_retire_select u_select (
        .head_valid_i     (rob_commit_retire_head_id_valid),
        .id_valid_i       (rob_commit_retire_id_valid),
        .finish_i         (finish),
        .has_exception_i  (has_exc),
        .pop_o            (sel_pop),
        .head_exception_o (head_exc)
    );

    // Next state and pop mask; the flush cycle ignores ROB contents entirely.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        pop     = '0;
        unique case (state_q)
            NORMAL: begin
                pop = sel_pop;
                if (head_exc) begin
                    pc_d    = rob_commit_retire_data[0].pc;
                    cause_d = rob_commit_retire_data[0].exception_id;
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
        if (rst) begin
            pop = '0;
        end
    end

    always_comb begin
        rel_valid_d = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            rel_id_d[i]    = rel_id_q[i];
            rel_valid_d[i] = pop[i] & rob_commit_retire_data[i].rd_valid;
            if (rel_valid_d[i]) begin
                rel_id_d[i] = rob_commit_retire_data[i].old_phy_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NORMAL;
            flush_q     <= 1'b0;
            pc_q        <= '0;
            cause_q     <= '0;
            rel_valid_q <= '0;
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
                rel_id_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_q     <= (state_d == FLUSH);
            pc_q        <= pc_d;
            cause_q     <= cause_d;
            rel_valid_q <= rel_valid_d;
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
                rel_id_q[i] <= rel_id_d[i];
            end
        end
    end

    assign commit_rob_retire_pop    = pop;
    assign commit_rob_flush         = flush_q;
    assign commit_redirect_valid    = flush_q;
    assign commit_redirect_pc       = pc_q;
    assign commit_exception_cause   = cause_q;
    assign commit_phy_release_valid = rel_valid_q;
    assign commit_phy_release_id    = rel_id_q;

`ifdef COMMIT_RETIRE_PERF_COUNTER_EN
    logic [RetireCntWidth-1:0] pop_cnt;
    logic [63:0]               retired_q;

    // Pop mask is contiguous from bit 0, so the run-length counter suffices.
    count_one #(
        .WIDTH      (COMMIT_WIDTH),
        .CONTINUOUS (1'b1),
        .CNT_WIDTH  (RetireCntWidth)
    ) u_pop_count (
        .data_i  (pop),
        .count_o (pop_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + 64'(pop_cnt);
        end
    end

    assign commit_retired_count = retired_q;
`endif

endmodule
